// File: rtl/scan_pkg.sv
// Shared types and constants for the knight-rider scan controller and its
// button debouncers.
package scan_pkg;

  localparam int SPEED_W = 2;
  localparam int POS_W   = 3;
  localparam int CNT_W   = 32;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    SHIFT_L = 2'd1,
    SHIFT_R = 2'd2,
    PAUSED  = 2'd3
  } state_t;

  typedef struct packed {
    state_t state;
    logic   btn1_pressed;
    logic   btn2_pressed;
  } dbg_t;

  // Step period for a speed setting; never below one cycle so the terminal
  // compare cannot underflow.
  function automatic logic [CNT_W-1:0] step_wait(input logic [CNT_W-1:0] base,
                                                 input logic [SPEED_W-1:0] spd);
    logic [CNT_W-1:0] w;
    w = base >> spd;
    return (w == '0) ? CNT_W'(1) : w;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronises an active-low raw button, debounces it and emits a one-cycle
// event on each debounced released->pressed transition.
module button_debounce #(
  parameter int DEBOUNCE_CYC = 270_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic pressed,
  output logic press_evt
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic          sync1;
  logic          sync2;
  logic          raw_pressed;
  logic [CW-1:0] stable_cnt;

  assign raw_pressed = ~sync2;

  // The new level is accepted on the DEBOUNCE_CYC-th consecutive cycle it
  // differs from the current debounced level; any agreement restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      pressed    <= 1'b0;
      press_evt  <= 1'b0;
      stable_cnt <= '0;
    end else begin
      sync1     <= btn_n;
      sync2     <= sync1;
      press_evt <= 1'b0;
      if (raw_pressed == pressed) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CW'(DEBOUNCE_CYC - 1)) begin
        pressed    <= raw_pressed;
        press_evt  <= raw_pressed;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/scan_controller.sv
// Sequencer for the 6-LED knight-rider scanner: step timer, scan position,
// sweep direction, and run/pause plus speed commands from two buttons.
module scan_controller
  import scan_pkg::*;
#(
  parameter int NUM_LEDS     = 6,
  parameter int BASE_WAIT    = 1_700_000,
  parameter int DEBOUNCE_CYC = 270_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               button1,
  input  logic               button2,
  output logic               step,
  output logic               dir,
  output logic [POS_W-1:0]   pos,
  output logic               running,
  output logic [SPEED_W-1:0] speed,
  output dbg_t               dbg
);

  localparam logic [POS_W-1:0] LAST_POS = POS_W'(NUM_LEDS - 1);

  state_t             state, state_n;
  logic [POS_W-1:0]   pos_n, pos_up, pos_dn;
  logic               dir_n, step_n;
  logic [SPEED_W-1:0] speed_n;
  logic [CNT_W-1:0]   cnt, cnt_n, wait_len;
  logic               terminal;
  logic               spd_evt, pause_evt;
  logic               b1_pressed, b2_pressed;

  button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_speed (
    .clk       (clk),
    .rst       (rst),
    .btn_n     (button1),
    .pressed   (b1_pressed),
    .press_evt (spd_evt)
  );

  button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_run (
    .clk       (clk),
    .rst       (rst),
    .btn_n     (button2),
    .pressed   (b2_pressed),
    .press_evt (pause_evt)
  );

  assign wait_len = step_wait(CNT_W'(BASE_WAIT), speed);
  assign terminal = (cnt >= wait_len - CNT_W'(1));
  assign pos_up   = pos + POS_W'(1);
  assign pos_dn   = pos - POS_W'(1);

  assign running = (state != PAUSED);
  assign dbg     = '{state: state, btn1_pressed: b1_pressed, btn2_pressed: b2_pressed};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
      pos   <= '0;
      dir   <= DIR_UP;
      step  <= 1'b0;
      speed <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      pos   <= pos_n;
      dir   <= dir_n;
      step  <= step_n;
      speed <= speed_n;
      cnt   <= cnt_n;
    end
  end

  // step, pos and dir are registered together, so a strobe always arrives with
  // the position and direction it produced. Speed and pause events both
  // suppress a coinciding step; the counter still restarts at terminal.
  always_comb begin
    state_n = state;
    pos_n   = pos;
    dir_n   = dir;
    step_n  = 1'b0;
    cnt_n   = cnt;
    speed_n = spd_evt ? speed + SPEED_W'(1) : speed;

    case (state)
      INIT: begin
        cnt_n   = '0;
        state_n = pause_evt ? PAUSED : SHIFT_L;
      end
      SHIFT_L, SHIFT_R: begin
        if (spd_evt) begin
          cnt_n = '0;
        end else if (terminal) begin
          cnt_n = '0;
          if (!pause_evt) begin
            step_n = 1'b1;
            if (state == SHIFT_L) begin
              pos_n = pos_up;
              if (pos_up == LAST_POS) begin
                dir_n   = DIR_DN;
                state_n = SHIFT_R;
              end
            end else begin
              pos_n = pos_dn;
              if (pos_dn == '0) begin
                dir_n   = DIR_UP;
                state_n = SHIFT_L;
              end
            end
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
        if (pause_evt) state_n = PAUSED;
      end
      PAUSED: begin
        if (spd_evt) cnt_n = '0;
        if (pause_evt) state_n = (dir == DIR_UP) ? SHIFT_L : SHIFT_R;
      end
      default: state_n = INIT;
    endcase
  end

endmodule

// File: tb/tb_scan_controller.sv
// Directed bench for scan_controller with a short step period and debounce
// window so whole sweeps and button presses fit in a few hundred cycles.
module tb_scan_controller;
  import scan_pkg::*;

  localparam int NUM_LEDS     = 6;
  localparam int BASE_WAIT    = 16;
  localparam int DEBOUNCE_CYC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       button1;
  logic       button2;
  logic       step;
  logic       dir;
  logic [2:0] pos;
  logic       running;
  logic [1:0] speed;
  dbg_t       dbg;

  int checks = 0;
  int passed = 0;
  logic [3:0] exp_q[$];

  scan_controller #(
    .NUM_LEDS     (NUM_LEDS),
    .BASE_WAIT    (BASE_WAIT),
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .button1 (button1),
    .button2 (button2),
    .step    (step),
    .dir     (dir),
    .pos     (pos),
    .running (running),
    .speed   (speed),
    .dbg     (dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Counts negedges until step is seen; returns max_cyc+1 on timeout.
  task automatic wait_step(input int max_cyc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!step && n <= max_cyc);
  endtask

  task automatic wait_running(input logic lvl, input int max_cyc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (running !== lvl && n <= max_cyc);
  endtask

  task automatic wait_speed(input logic [1:0] val, input int max_cyc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (speed !== val && n <= max_cyc);
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  int pos_seq[11] = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1};
  int dir_seq[11] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0};
  int ival_seq[4] = '{8, 4, 2, 16};

  initial begin
    int n;
    int steps_seen;
    int guard;
    logic [3:0] exp;
    logic [2:0] pos_hold;
    logic       dir_hold;

    rst     = 1'b1;
    button1 = 1'b1;
    button2 = 1'b1;
    idle(3);
    check("rst_pos", 32'(pos), 0);
    check("rst_dir", 32'(dir), 0);
    check("rst_step", 32'(step), 0);
    check("rst_running", 32'(running), 1);
    check("rst_speed", 32'(speed), 0);
    check("rst_state", 32'(dbg.state), 32'(INIT));

    // 1: free-running sweep
    rst = 1'b0;
    @(negedge clk);
    check("t1_left_init", 32'(dbg.state), 32'(SHIFT_L));
    for (int i = 0; i < 11; i++) exp_q.push_back(4'(dir_seq[i] * 8 + pos_seq[i]));
    for (int i = 0; i < 11; i++) begin
      wait_step(40, n);
      check("t1_interval", n, 16);
      exp = exp_q.pop_front();
      check("t1_dir_pos", 32'({dir, pos}), 32'(exp));
    end

    // 2: pause mid-interval (press lands on cnt=7), then resume
    pos_hold = pos;
    dir_hold = dir;
    @(negedge clk);
    button2 = 1'b0;
    idle(10);
    button2 = 1'b1;
    check("t2_paused_running", 32'(running), 0);
    check("t2_paused_state", 32'(dbg.state), 32'(PAUSED));
    steps_seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (step) steps_seen++;
    end
    check("t2_no_step", steps_seen, 0);
    check("t2_pos_held", 32'(pos), 32'(pos_hold));
    button2 = 1'b0;
    wait_running(1'b1, 20, n);
    check("t2_resume_latency", n, 2 + DEBOUNCE_CYC + 1);
    check("t2_resume_dir_pos", 32'({dir, pos}), 32'({dir_hold, pos_hold}));
    wait_step(40, n);
    check("t2_resume_step", n, 8);
    check("t2_pos_after", 32'(pos), 32'(pos_hold + 3'd1));
    button2 = 1'b1;
    idle(20);

    // 3: speed cycling
    for (int k = 0; k < 4; k++) begin
      button1 = 1'b0;
      wait_speed(2'((k + 1) % 4), 20, n);
      check("t3_latency", n, 2 + DEBOUNCE_CYC + 1);
      check("t3_speed", 32'(speed), (k + 1) % 4);
      wait_step(40, n);
      check("t3_first_interval", n, ival_seq[k]);
      wait_step(40, n);
      check("t3_interval", n, ival_seq[k]);
      button1 = 1'b1;
      idle(50);
    end

    // 4: bouncing button gives nothing, a clean hold gives one increment
    for (int i = 0; i < 20; i++) begin
      button1 = ~button1;
      idle(2);
    end
    button1 = 1'b1;
    idle(10);
    check("t4_bounce_speed", 32'(speed), 0);
    button1 = 1'b0;
    idle(100);
    check("t4_hold_speed", 32'(speed), 1);
    button1 = 1'b1;
    idle(20);
    check("t4_release_speed", 32'(speed), 1);

    // 5: asynchronous reset while paused at pos 3 going down, speed 2
    button1 = 1'b0;
    idle(10);
    button1 = 1'b1;
    idle(10);
    check("t5_speed2", 32'(speed), 2);
    guard = 0;
    while (!(step && pos == 3'd4 && dir) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("t5_found_pos4", 32'(guard < 200), 1);
    button2 = 1'b0;
    idle(10);
    check("t5_pre_running", 32'(running), 0);
    check("t5_pre_dir_pos", 32'({dir, pos}), 32'({1'b1, 3'd3}));
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t5_async_pos", 32'(pos), 0);
    check("t5_async_dir", 32'(dir), 0);
    check("t5_async_speed", 32'(speed), 0);
    check("t5_async_running", 32'(running), 1);
    check("t5_async_step", 32'(step), 0);
    button2 = 1'b1;
    idle(3);
    rst = 1'b0;

    // 6: pause event on the terminal-count cycle
    wait_step(40, n);
    check("t6_first_step", n, 17);
    pos_hold = pos;
    idle(9);
    button2 = 1'b0;
    steps_seen = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (step) steps_seen++;
    end
    check("t6_no_step", steps_seen, 0);
    check("t6_running", 32'(running), 0);
    check("t6_pos", 32'(pos), 32'(pos_hold));
    button2 = 1'b1;
    idle(10);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
